wb_pipe_reg: RTL and testbench



---
 rtl/y86_pkg.sv | 26 ++
 rtl/wb_pipe_reg.sv | 133 +++++++++++++
 tb/tb_wb_pipe_reg.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 pipelined core: status codes, the
// instruction code for a nop, the "no register" ID and default field widths.
// ---------------------------------------------------------------------------
package y86_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_REG_W   = 4;
    localparam int DEF_ICODE_W = 4;
    localparam int DEF_STAT_W  = 3;
    localparam int DEF_CNT_W   = 32;

    // Pipeline status codes carried alongside each instruction.
    typedef enum logic [DEF_STAT_W-1:0] {
        SBUB = 3'd0,
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    localparam logic [DEF_ICODE_W-1:0] INOP  = 4'h1;
    localparam logic [DEF_REG_W-1:0]   RNONE = 4'hF;

endpackage : y86_pkg

// File: rtl/wb_pipe_reg.sv
// ---------------------------------------------------------------------------
// wb_pipe_reg
// Memory -> Writeback pipeline register for the Y86-64 pipelined core.
// Captures the M-stage results once per clock, with stall (hold), bubble
// (load a nop) and a sticky halt latch that freezes the stage once an
// exceptional status (halt, address error, illegal instruction) reaches W.
// Priority on each edge: halted > stall > bubble > load.
//
// Optional build macro WB_RETIRE_CNT_EN:
//   defined   - W_retired counts instructions loaded with status SAOK
//   undefined - no counter is built, W_retired is tied to zero
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   W_stall, W_bubble     pipeline control from the hazard unit
//   M_icode, M_valE,
//   M_dstE, M_dstM        instruction fields from the M stage
//   m_stat, m_valM        status and read data from the memory stage
//   W_icode .. W_stat     registered W-stage fields
//   W_halted              sticky, set when an exceptional status enters W
//   W_ctl_err             stall and bubble were both asserted last cycle
//   W_retired             retired-instruction count
// ---------------------------------------------------------------------------
module wb_pipe_reg
    import y86_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int ICODE_W = DEF_ICODE_W,
    parameter int STAT_W  = DEF_STAT_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               W_stall,
    input  logic               W_bubble,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [DATA_W-1:0]  M_valE,
    input  logic [REG_W-1:0]   M_dstE,
    input  logic [REG_W-1:0]   M_dstM,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [DATA_W-1:0]  m_valM,
    output logic [ICODE_W-1:0] W_icode,
    output logic [DATA_W-1:0]  W_valE,
    output logic [DATA_W-1:0]  W_valM,
    output logic [REG_W-1:0]   W_dstE,
    output logic [REG_W-1:0]   W_dstM,
    output logic [STAT_W-1:0]  W_stat,
    output logic               W_halted,
    output logic               W_ctl_err,
    output logic [CNT_W-1:0]   W_retired
);

    localparam logic [ICODE_W-1:0] BUB_ICODE = ICODE_W'(INOP);
    localparam logic [REG_W-1:0]   BUB_REG   = {REG_W{1'b1}};
    localparam logic [STAT_W-1:0]  BUB_STAT  = STAT_W'(SBUB);

    logic load_en;
    logic stat_exc;
    logic stat_aok;

    assign load_en  = !W_halted && !W_stall && !W_bubble;
    assign stat_exc = (m_stat == STAT_W'(SHLT)) ||
                      (m_stat == STAT_W'(SADR)) ||
                      (m_stat == STAT_W'(SINS));
    assign stat_aok = (m_stat == STAT_W'(SAOK));

    // Data registers. Halted and stalled cases hold by not assigning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_icode <= BUB_ICODE;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= BUB_REG;
            W_dstM  <= BUB_REG;
            W_stat  <= BUB_STAT;
        end else if (!W_halted && !W_stall) begin
            if (W_bubble) begin
                W_icode <= BUB_ICODE;
                W_valE  <= '0;
                W_valM  <= '0;
                W_dstE  <= BUB_REG;
                W_dstM  <= BUB_REG;
                W_stat  <= BUB_STAT;
            end else begin
                W_icode <= M_icode;
                W_valE  <= M_valE;
                W_valM  <= m_valM;
                W_dstE  <= M_dstE;
                W_dstM  <= M_dstM;
                W_stat  <= m_stat;
            end
        end
    end

    // Halt latch only sets on an edge that actually loads the exceptional
    // instruction, so a stalled or bubbled exception never freezes W early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_halted <= 1'b0;
        end else if (load_en && stat_exc) begin
            W_halted <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_ctl_err <= 1'b0;
        end else begin
            W_ctl_err <= W_stall && W_bubble;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q;

    // Wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (load_en && stat_aok) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign W_retired = retired_q;
`else
    logic unused_aok;
    assign unused_aok = stat_aok;
    assign W_retired  = '0;
`endif

endmodule : wb_pipe_reg

// File: tb/tb_wb_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_wb_pipe_reg
// Directed self-checking bench for wb_pipe_reg. The counter is built with
// CNT_W=4 so that the wrap case is short; expected counts follow whether
// WB_RETIRE_CNT_EN is defined for this build.
// ---------------------------------------------------------------------------
module tb_wb_pipe_reg;

    localparam int DATA_W  = 64;
    localparam int REG_W   = 4;
    localparam int ICODE_W = 4;
    localparam int STAT_W  = 3;
    localparam int CNT_W   = 4;

    logic               clk;
    logic               rst_n;
    logic               W_stall;
    logic               W_bubble;
    logic [ICODE_W-1:0] M_icode;
    logic [DATA_W-1:0]  M_valE;
    logic [REG_W-1:0]   M_dstE;
    logic [REG_W-1:0]   M_dstM;
    logic [STAT_W-1:0]  m_stat;
    logic [DATA_W-1:0]  m_valM;
    logic [ICODE_W-1:0] W_icode;
    logic [DATA_W-1:0]  W_valE;
    logic [DATA_W-1:0]  W_valM;
    logic [REG_W-1:0]   W_dstE;
    logic [REG_W-1:0]   W_dstM;
    logic [STAT_W-1:0]  W_stat;
    logic               W_halted;
    logic               W_ctl_err;
    logic [CNT_W-1:0]   W_retired;

    int vectors;
    int miscompares;
    logic [CNT_W-1:0] expRet;

    wb_pipe_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .ICODE_W(ICODE_W),
        .STAT_W (STAT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .W_stall  (W_stall),
        .W_bubble (W_bubble),
        .M_icode  (M_icode),
        .M_valE   (M_valE),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
        .m_stat   (m_stat),
        .m_valM   (m_valM),
        .W_icode  (W_icode),
        .W_valE   (W_valE),
        .W_valM   (W_valM),
        .W_dstE   (W_dstE),
        .W_dstM   (W_dstM),
        .W_stat   (W_stat),
        .W_halted (W_halted),
        .W_ctl_err(W_ctl_err),
        .W_retired(W_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one set of inputs, then let one rising edge pass and settle.
    task automatic applyStimulus(input logic stall, input logic bubble,
                                 input logic [3:0] icode, input logic [63:0] valE,
                                 input logic [3:0] dstE, input logic [3:0] dstM,
                                 input logic [2:0] stat, input logic [63:0] valM);
        W_stall  = stall;
        W_bubble = bubble;
        M_icode  = icode;
        M_valE   = valE;
        M_dstE   = dstE;
        M_dstM   = dstM;
        m_stat   = stat;
        m_valM   = valM;
        @(posedge clk);
        #1;
    endtask

    task automatic checkRetired(input string tag);
`ifdef WB_RETIRE_CNT_EN
        checkOutput(tag, 64'(W_retired), 64'(expRet));
`else
        checkOutput(tag, 64'(W_retired), 64'd0);
`endif
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, "_icode"}, 64'(W_icode), 64'h1);
        checkOutput({tag, "_valE"},  W_valE, 64'h0);
        checkOutput({tag, "_valM"},  W_valM, 64'h0);
        checkOutput({tag, "_dstE"},  64'(W_dstE), 64'hF);
        checkOutput({tag, "_dstM"},  64'(W_dstM), 64'hF);
        checkOutput({tag, "_stat"},  64'(W_stat), 64'h0);
    endtask

    // Assert reset between edges and check immediately, then release it
    // just after the following edge.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkBubble(tag);
        checkOutput({tag, "_halted"}, 64'(W_halted), 64'h0);
        checkOutput({tag, "_ctlerr"}, 64'(W_ctl_err), 64'h0);
        expRet = '0;
        checkRetired({tag, "_ret"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        expRet      = '0;
        rst_n       = 1'b1;
        W_stall     = 1'b0;
        W_bubble    = 1'b0;
        M_icode     = '0;
        M_valE      = '0;
        M_dstE      = '0;
        M_dstM      = '0;
        m_stat      = '0;
        m_valM      = '0;

        // Reset in the middle of the first cycle, before any clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        checkBubble("rst0");
        checkOutput("rst0_halted", 64'(W_halted), 64'h0);
        checkOutput("rst0_ctlerr", 64'(W_ctl_err), 64'h0);
        checkRetired("rst0_ret");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Plain load of an AOK instruction.
        applyStimulus(0, 0, 4'h3, 64'h1234, 4'h2, 4'hF, 3'd1, 64'hABCD);
        expRet = expRet + 1'b1;
        checkOutput("load_icode", 64'(W_icode), 64'h3);
        checkOutput("load_valE",  W_valE, 64'h1234);
        checkOutput("load_valM",  W_valM, 64'hABCD);
        checkOutput("load_dstE",  64'(W_dstE), 64'h2);
        checkOutput("load_dstM",  64'(W_dstM), 64'hF);
        checkOutput("load_stat",  64'(W_stat), 64'h1);
        checkRetired("load_ret");

        // Stall for three cycles while M changes, including an exceptional
        // status that must not set the halt latch while stalled.
        applyStimulus(1, 0, 4'h6, 64'h1111, 4'h5, 4'h7, 3'd1, 64'h2222);
        applyStimulus(1, 0, 4'h0, 64'h3333, 4'h8, 4'h9, 3'd2, 64'h4444);
        applyStimulus(1, 0, 4'h5, 64'h5555, 4'hA, 4'hB, 3'd1, 64'h6666);
        checkOutput("stall_icode", 64'(W_icode), 64'h3);
        checkOutput("stall_valE",  W_valE, 64'h1234);
        checkOutput("stall_valM",  W_valM, 64'hABCD);
        checkOutput("stall_dstE",  64'(W_dstE), 64'h2);
        checkOutput("stall_halted", 64'(W_halted), 64'h0);
        checkOutput("stall_ctlerr", 64'(W_ctl_err), 64'h0);
        checkRetired("stall_ret");

        // Bubble injection.
        applyStimulus(0, 1, 4'h6, 64'h7777, 4'h3, 4'h4, 3'd1, 64'h8888);
        checkBubble("bub");
        checkRetired("bub_ret");

        // Stall and bubble together: hold wins, conflict flagged next cycle.
        applyStimulus(1, 1, 4'h6, 64'h9999, 4'h3, 4'h4, 3'd1, 64'hAAAA);
        checkBubble("conf");
        checkOutput("conf_ctlerr", 64'(W_ctl_err), 64'h1);
        checkRetired("conf_ret");

        // Conflict clears on the next normal load.
        applyStimulus(0, 0, 4'h6, 64'hBEEF, 4'h3, 4'h4, 3'd1, 64'hCAFE);
        expRet = expRet + 1'b1;
        checkOutput("after_ctlerr", 64'(W_ctl_err), 64'h0);
        checkOutput("after_valE",   W_valE, 64'hBEEF);
        checkOutput("after_dstM",   64'(W_dstM), 64'h4);
        checkRetired("after_ret");

        // Halt enters W and freezes the stage.
        applyStimulus(0, 0, 4'h0, 64'h55, 4'hF, 4'hF, 3'd2, 64'h66);
        checkOutput("hlt_halted", 64'(W_halted), 64'h1);
        checkOutput("hlt_icode",  64'(W_icode), 64'h0);
        checkOutput("hlt_stat",   64'(W_stat), 64'h2);
        checkOutput("hlt_valE",   W_valE, 64'h55);
        checkRetired("hlt_ret");
        applyStimulus(0, 0, 4'h6, 64'h99, 4'h1, 4'h1, 3'd1, 64'h77);
        applyStimulus(0, 1, 4'h6, 64'h98, 4'h1, 4'h1, 3'd1, 64'h76);
        applyStimulus(0, 0, 4'h6, 64'h97, 4'h1, 4'h1, 3'd1, 64'h75);
        checkOutput("hold_halted", 64'(W_halted), 64'h1);
        checkOutput("hold_icode",  64'(W_icode), 64'h0);
        checkOutput("hold_stat",   64'(W_stat), 64'h2);
        checkOutput("hold_valE",   W_valE, 64'h55);
        checkOutput("hold_valM",   W_valM, 64'h66);
        checkRetired("hold_ret");

        // Reset pulse clears everything, including the halt latch.
        pulseReset("rst1");
        applyStimulus(0, 0, 4'h2, 64'h42, 4'h3, 4'h0, 3'd1, 64'h43);
        expRet = expRet + 1'b1;
        checkOutput("rst1_load_icode", 64'(W_icode), 64'h2);
        checkOutput("rst1_load_valE",  W_valE, 64'h42);
        checkRetired("rst1_load_ret");

        // Address error also halts and is not counted.
        applyStimulus(0, 0, 4'h5, 64'hDEAD, 4'h1, 4'h2, 3'd3, 64'h0);
        checkOutput("adr_halted", 64'(W_halted), 64'h1);
        checkOutput("adr_stat",   64'(W_stat), 64'h3);
        checkRetired("adr_ret");

        // Illegal instruction after a fresh reset.
        pulseReset("rst2");
        applyStimulus(0, 0, 4'hE, 64'h1, 4'h1, 4'h1, 3'd4, 64'h2);
        checkOutput("ins_halted", 64'(W_halted), 64'h1);
        checkOutput("ins_icode",  64'(W_icode), 64'hE);
        checkRetired("ins_ret");

        // Seventeen AOK loads wrap a 4-bit counter to 1.
        pulseReset("rst3");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, 0, 4'h6, 64'(i + 100), 4'h3, 4'hF, 3'd1, 64'(i));
            expRet = expRet + 1'b1;
        end
        checkOutput("wrap_valE", W_valE, 64'd116);
        checkOutput("wrap_halted", 64'(W_halted), 64'h0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("wrap_ret", 64'(W_retired), 64'd1);
`else
        checkOutput("wrap_ret", 64'(W_retired), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_wb_pipe_reg
